// File: rtl/seq_mult16_pkg.sv
// Shared types and constants for the sequential 16x16 shift-and-add multiplier.
package mult_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_ITER = 5'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/seq_mult16_cla16bit.sv
// 16-bit carry-lookahead adder.
// The adder is built from four 4-bit groups, each with its own group generate/propagate.
module cla16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic        gen,
    output logic        pro
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  gc;

    always_comb begin
        g = a & b;
        p = a ^ b;
        for (int unsigned k = 0; k < 4; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end

        // Group carries are expanded fully from cin so no carry depends on another carry.
        gc[0] = cin;
        gc[1] = grp_g[0] | (grp_p[0] & cin);
        gc[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
        gc[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
              | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
        gc[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
              | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
              | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

        for (int unsigned k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end

        sum  = p ^ c;
        cout = gc[4];
        gen  = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
        pro  = &grp_p;
    end

endmodule

// File: rtl/seq_mult16.sv
// Sequential 16x16 unsigned shift-and-add multiplier with valid/ready on both sides.
// One multiplicand-or-zero partial sum per cycle; 16 iterations per product.
module seq_mult16
    import mult_pkg::*;
#(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    mult_state_t      state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] cla_sum;
    logic             cla_cout;
    logic             cla_gen_unused;
    logic             cla_pro_unused;

    assign add_b = lo_q[0] ? m_q : '0;

    cla16bit u_cla (
        .a    (hi_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (cla_sum),
        .cout (cla_cout),
        .gen  (cla_gen_unused),
        .pro  (cla_pro_unused)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = a;
                    hi_d    = '0;
                    lo_d    = b;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // cout lands in hi[15], so the 17th bit of every partial sum is kept.
                hi_d  = {cla_cout, cla_sum[WIDTH-1:1]};
                lo_d  = {cla_sum[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = {hi_q, lo_q};

endmodule

// File: tb/tb_seq_mult16.sv
// Self-checking bench for seq_mult16: directed scenarios plus a random sweep against a*b.
module tb_seq_mult16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    seq_mult16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] xx;
        logic [31:0] yy;
        xx = {16'h0000, x};
        yy = {16'h0000, y};
        return xx * yy;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation: waits for in_ready, offers operands for one edge,
    // counts cycles until out_valid, stalls `gap` cycles, then takes the product.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input int gap,
                         output logic [31:0] prod, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 40) begin
            tick();
            w++;
        end
        in_valid = 1'b1;
        a = x;
        b = y;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        for (int i = 0; i < gap; i++) begin
            tick();
        end
        prod = product;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h5678;
        out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs out_valid=%b busy=%b exp=0/0", out_valid, busy);
        end
        checks++;
        if (product !== 32'h0) begin
            failures++;
            $display("FAIL reset_product got=%h exp=00000000", product);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 16'h0003;
        b = 16'h0005;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL basic_run_flags busy=%b in_ready=%b exp=1/0", busy, in_ready);
            end
            tick();
            lat++;
        end
        checks++;
        if (lat !== 16) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=16", lat);
        end
        checks++;
        if (product !== 32'h0000000F) begin
            failures++;
            $display("FAIL basic_product got=%h exp=0000000f", product);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_return_idle in_ready=%b out_valid=%b busy=%b exp=1/0/0",
                     in_ready, out_valid, busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_max();
        logic [31:0] p;
        int lat;
        do_op(16'hFFFF, 16'hFFFF, 0, p, lat);
        checks++;
        if (p !== 32'hFFFE0001 || lat !== 16) begin
            failures++;
            $display("FAIL max_product got=%h lat=%0d exp=fffe0001 lat=16", p, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] got_q[$];
        logic [31:0] p;
        int lat;
        logic [31:0] e;
        exp_q.push_back(ref_mul(16'h0000, 16'hBEEF));
        exp_q.push_back(ref_mul(16'h1234, 16'h0001));
        do_op(16'h0000, 16'hBEEF, 0, p, lat);
        got_q.push_back(p);
        do_op(16'h1234, 16'h0001, 0, p, lat);
        got_q.push_back(p);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            p = got_q.pop_front();
            checks++;
            if (p !== e) begin
                failures++;
                $display("FAIL b2b_product[%0d] got=%h exp=%h", i, p, e);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int lat;
        in_valid = 1'b1;
        a = 16'h00AB;
        b = 16'h0C0D;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        held = product;
        checks++;
        if (held !== ref_mul(16'h00AB, 16'h0C0D)) begin
            failures++;
            $display("FAIL bp_product got=%h exp=%h", held, ref_mul(16'h00AB, 16'h0C0D));
        end
        in_valid = 1'b1;
        a = 16'h0007;
        b = 16'h0003;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || product !== held || in_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d] out_valid=%b product=%h in_ready=%b busy=%b exp=1/%h/0/1",
                         i, out_valid, product, in_ready, busy, held);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release busy=%b out_valid=%b exp=0/0", busy, out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] p;
        int lat;
        int seen;
        in_valid = 1'b1;
        a = 16'h00FF;
        b = 16'h0101;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_idle busy=%b in_ready=%b out_valid=%b exp=0/1/0",
                     busy, in_ready, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL midrst_no_output got=%0d valid cycles exp=0", seen);
        end
        do_op(16'h00FF, 16'h0101, 0, p, lat);
        checks++;
        if (p !== 32'h0000FFFF) begin
            failures++;
            $display("FAIL midrst_rerun got=%h exp=0000ffff", p);
        end
    endtask

    task automatic test_random();
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] p;
        int lat;
        int gap;
        for (int n = 0; n < 1000; n++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            case (n)
                0: x = 16'h0000;
                1: y = 16'h0000;
                2: begin x = 16'hFFFF; y = 16'h0001; end
                3: begin x = 16'h8000; y = 16'h8000; end
                default: ;
            endcase
            gap = int'($urandom_range(0, 3));
            do_op(x, y, gap, p, lat);
            checks++;
            if (p !== ref_mul(x, y) || lat !== 16) begin
                failures++;
                $display("FAIL rand[%0d] a=%h b=%h got=%h lat=%0d exp=%h lat=16",
                         n, x, y, p, lat, ref_mul(x, y));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_max();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
